dm_wb_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate cache with four-word (128-bit) lines.
- Responds to the pipeline's word-addressed ICACHE/DCACHE request interface and acts as initiator toward the slow 128-bit line memory.
- One instance serves instruction fetch, one serves loads/stores, both between `RISCV_Pipeline` and the slow memories in `CHIP`.

---
 rtl/dm_wb_cache.sv | 150 +++++++++++++++
 tb/tb_dm_wb_cache.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_wb_cache.sv
// Direct-mapped write-back write-allocate cache, 4-word lines.
// Define DM_WB_CACHE_PERF_EN to add saturating hit_cnt/miss_cnt outputs.
module dm_wb_cache #(
  parameter int BLOCKS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef DM_WB_CACHE_PERF_EN
  ,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt
`endif
);

  localparam int IDX = $clog2(BLOCKS);
  localparam int TAG = 28 - IDX;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state_q;

  logic [BLOCKS-1:0] valid_q;
  logic [BLOCKS-1:0] dirty_q;
  logic [TAG-1:0]    tag_q  [BLOCKS];
  logic [127:0]      data_q [BLOCKS];

  logic [TAG-1:0] ptag;
  logic [IDX-1:0] idx;
  logic [1:0]     off;
  logic [TAG-1:0] ftag;
  logic [IDX-1:0] fidx;
  logic           req;
  logic           hit;
  logic [127:0]   line;

  assign ptag = proc_addr[29:2+IDX];
  assign idx  = proc_addr[1+IDX:2];
  assign off  = proc_addr[1:0];
  assign req  = proc_read | proc_write;
  assign line = data_q[idx];
  assign hit  = valid_q[idx] && (tag_q[idx] == ptag);

  // Fill target comes from the latched line address, not the live request.
  assign ftag = mem_addr[27:IDX];
  assign fidx = mem_addr[IDX-1:0];

  assign proc_stall = (state_q != COMPARE) | (req & ~hit);
  assign proc_rdata = (state_q == COMPARE && hit)
                    ? line[{off, 5'd0} +: 32] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COMPARE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
    end else begin
      unique case (state_q)
        COMPARE: begin
          if (req && !hit) begin
            if (valid_q[idx] && dirty_q[idx]) begin
              state_q   <= WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {tag_q[idx], idx};
              mem_wdata <= line;
            end else begin
              state_q  <= ALLOCATE;
              mem_read <= 1'b1;
              mem_addr <= {ptag, idx};
            end
          end else if (proc_write && hit) begin
            dirty_q[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            if (req) begin
              state_q  <= ALLOCATE;
              mem_read <= 1'b1;
              mem_addr <= {ptag, idx};
            end else begin
              state_q <= COMPARE;
            end
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            state_q       <= COMPARE;
            mem_read      <= 1'b0;
            valid_q[fidx] <= 1'b1;
            dirty_q[fidx] <= 1'b0;
          end
        end
        default: state_q <= COMPARE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ALLOCATE && mem_ready) begin
      data_q[fidx] <= mem_rdata;
      tag_q[fidx]  <= ftag;
    end else if (state_q == COMPARE && proc_write && hit) begin
      data_q[idx][{off, 5'd0} +: 32] <= proc_wdata;
    end
  end

`ifdef DM_WB_CACHE_PERF_EN
  // Set between a miss and its completion so the final hit isn't counted.
  logic missed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      missed_q <= 1'b0;
    end else if (state_q == COMPARE) begin
      if (req && !hit) begin
        missed_q <= 1'b1;
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end else begin
        missed_q <= 1'b0;
        if (req && !missed_q && hit_cnt != 16'hFFFF)
          hit_cnt <= hit_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_wb_cache.sv
// Randomized bench for dm_wb_cache against a word-level memory model.
// Tracks coherent word values plus a per-index occupancy model.
module tb_dm_wb_cache;
  localparam int LAT = 6;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         proc_read = 0;
  logic         proc_write = 0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 0;
`ifdef DM_WB_CACHE_PERF_EN
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;
  int           ref_hits = 0;
  int           ref_misses = 0;
`endif

  int tests = 0;
  int fails = 0;
  int cnt = 0;
  bit both_hi = 0;

  logic [127:0] mem_store [logic [27:0]];
  logic [31:0]  gold_w [logic [29:0]];
  bit           rv [8];
  bit           rd [8];
  logic [24:0]  rt [8];

  dm_wb_cache dut (
    .clk(clk), .rst_n(rst_n),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DM_WB_CACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] line_of(input logic [27:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return {a, 2'd3, 2'b10, a, 2'd2, 2'b10,
            a, 2'd1, 2'b10, a, 2'd0, 2'b10};
  endfunction

  function automatic logic [31:0] gold(input logic [29:0] a);
    logic [127:0] l;
    if (gold_w.exists(a)) return gold_w[a];
    l = line_of(a[29:2]);
    return l[32*a[1:0] +: 32];
  endfunction

  // Slow memory: ready pulses on the LAT-th cycle of a request.
  always @(negedge clk) begin
    if (mem_read && mem_write) both_hi = 1;
    if (mem_ready) begin
      mem_ready = 0;
      cnt = 0;
    end
    if (rst_n && (mem_read || mem_write)) begin
      cnt++;
      if (cnt == LAT) begin
        if (mem_write) mem_store[mem_addr] = mem_wdata;
        else mem_rdata = line_of(mem_addr);
        mem_ready = 1;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic model(
    input  bit           w,
    input  logic [29:0]  a,
    input  logic [31:0]  d,
    output int           es,
    output bit           ewb,
    output logic [27:0]  ewb_addr,
    output logic [127:0] ewb_line,
    output logic [31:0]  erd
  );
    int i;
    i = int'(a[4:2]);
    ewb = 0;
    ewb_addr = '0;
    ewb_line = '0;
    if (rv[i] && rt[i] == a[29:5]) begin
      es = 0;
`ifdef DM_WB_CACHE_PERF_EN
      ref_hits++;
`endif
    end else begin
      es = 1 + LAT;
`ifdef DM_WB_CACHE_PERF_EN
      ref_misses++;
`endif
      if (rv[i] && rd[i]) begin
        ewb = 1;
        es += LAT;
        ewb_addr = {rt[i], a[4:2]};
        for (int k = 0; k < 4; k++)
          ewb_line[32*k +: 32] = gold({ewb_addr, 2'(k)});
      end
      rv[i] = 1;
      rt[i] = a[29:5];
      rd[i] = 0;
    end
    if (w) begin
      rd[i] = 1;
      gold_w[a] = d;
    end
    erd = gold(a);
  endtask

  task automatic access(
    input  bit           w,
    input  logic [29:0]  a,
    input  logic [31:0]  d,
    output logic [31:0]  rdata,
    output int           stalls,
    output bit           wb,
    output logic [27:0]  wb_addr,
    output logic [127:0] wb_line,
    output bit           fill,
    output logic [27:0]  fill_addr,
    output bit           tmo
  );
    stalls = 0;
    wb = 0;
    fill = 0;
    tmo = 0;
    wb_addr = '0;
    wb_line = '0;
    fill_addr = '0;
    @(posedge clk);
    #1;
    proc_read = !w;
    proc_write = w;
    proc_addr = a;
    proc_wdata = d;
    forever begin
      @(negedge clk);
      if (mem_write && !wb) begin
        wb = 1;
        wb_addr = mem_addr;
        wb_line = mem_wdata;
      end
      if (mem_read && !fill) begin
        fill = 1;
        fill_addr = mem_addr;
      end
      if (!proc_stall) break;
      stalls++;
      if (stalls > 100) begin
        tmo = 1;
        break;
      end
    end
    rdata = proc_rdata;
    @(posedge clk);
    #1;
    proc_read = 0;
    proc_write = 0;
  endtask

  logic [31:0]  r_data, e_rd;
  int           r_st, e_st;
  bit           r_wb, r_fill, r_tmo, e_wb;
  logic [27:0]  r_wba, r_fa, e_wba;
  logic [127:0] r_wbl, e_wbl;

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (proc_stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_stall got %b want 0", proc_stall);
    end
    tests++;
    if ({mem_read, mem_write} !== 2'b00) begin
      fails++;
      $display("FAIL reset_req got %b want 00", {mem_read, mem_write});
    end
    tests++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      fails++;
      $display("FAIL reset_mem got %h/%h want 0", mem_addr, mem_wdata);
    end
    tests++;
    if (proc_rdata !== '0) begin
      fails++;
      $display("FAIL reset_rdata got %h want 0", proc_rdata);
    end
`ifdef DM_WB_CACHE_PERF_EN
    tests++;
    if (hit_cnt !== '0 || miss_cnt !== '0) begin
      fails++;
      $display("FAIL reset_cnt got %h/%h want 0", hit_cnt, miss_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_clean_fill();
    mem_store[28'h4] = 128'h44444444_33333333_22222222_11111111;
    model(0, 30'h10, 0, e_st, e_wb, e_wba, e_wbl, e_rd);
    access(0, 30'h10, 0, r_data, r_st, r_wb, r_wba, r_wbl, r_fill, r_fa, r_tmo);
    tests++;
    if (!r_fill || r_fa !== 28'h4 || r_wb) begin
      fails++;
      $display("FAIL fill_addr got %b/%h wb=%b want 1/4 wb=0", r_fill, r_fa, r_wb);
    end
    tests++;
    if (r_st != 7 || r_tmo) begin
      fails++;
      $display("FAIL fill_stall got %0d want 7", r_st);
    end
    tests++;
    if (r_data !== 32'h11111111) begin
      fails++;
      $display("FAIL fill_rdata got %h want 11111111", r_data);
    end
    model(0, 30'h11, 0, e_st, e_wb, e_wba, e_wbl, e_rd);
    access(0, 30'h11, 0, r_data, r_st, r_wb, r_wba, r_wbl, r_fill, r_fa, r_tmo);
    tests++;
    if (r_st != 0 || r_data !== 32'h22222222) begin
      fails++;
      $display("FAIL hit_read got %0d/%h want 0/22222222", r_st, r_data);
    end
  endtask

  task automatic test_write_hit();
    model(1, 30'h10, 32'hDEADBEEF, e_st, e_wb, e_wba, e_wbl, e_rd);
    access(1, 30'h10, 32'hDEADBEEF, r_data, r_st, r_wb, r_wba, r_wbl, r_fill, r_fa, r_tmo);
    tests++;
    if (r_st != 0 || r_wb || r_fill) begin
      fails++;
      $display("FAIL write_hit got stall=%0d wb=%b fill=%b want 0/0/0", r_st, r_wb, r_fill);
    end
    model(0, 30'h10, 0, e_st, e_wb, e_wba, e_wbl, e_rd);
    access(0, 30'h10, 0, r_data, r_st, r_wb, r_wba, r_wbl, r_fill, r_fa, r_tmo);
    tests++;
    if (r_st != 0 || r_data !== 32'hDEADBEEF || r_wb) begin
      fails++;
      $display("FAIL write_readback got %0d/%h want 0/deadbeef", r_st, r_data);
    end
  endtask

  task automatic test_dirty_evict();
    model(0, 30'h30, 0, e_st, e_wb, e_wba, e_wbl, e_rd);
    access(0, 30'h30, 0, r_data, r_st, r_wb, r_wba, r_wbl, r_fill, r_fa, r_tmo);
    tests++;
    if (!r_wb || r_wba !== 28'h4 || r_wbl[31:0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL evict_wb got %b/%h/%h want 1/4/deadbeef", r_wb, r_wba, r_wbl[31:0]);
    end
    tests++;
    if (r_wbl !== e_wbl) begin
      fails++;
      $display("FAIL evict_line got %h want %h", r_wbl, e_wbl);
    end
    tests++;
    if (!r_fill || r_fa !== 28'hC || r_st != 13) begin
      fails++;
      $display("FAIL evict_fill got %h stall=%0d want c stall=13", r_fa, r_st);
    end
    tests++;
    if (r_data !== e_rd) begin
      fails++;
      $display("FAIL evict_rdata got %h want %h", r_data, e_rd);
    end
  endtask

  task automatic test_write_miss();
    model(1, 30'h44, 32'hA5A5A5A5, e_st, e_wb, e_wba, e_wbl, e_rd);
    access(1, 30'h44, 32'hA5A5A5A5, r_data, r_st, r_wb, r_wba, r_wbl, r_fill, r_fa, r_tmo);
    tests++;
    if (!r_fill || r_fa !== 28'h11 || r_wb || r_st != 7) begin
      fails++;
      $display("FAIL wmiss_fill got %b/%h wb=%b stall=%0d want 1/11/0/7", r_fill, r_fa, r_wb, r_st);
    end
    model(0, 30'h44, 0, e_st, e_wb, e_wba, e_wbl, e_rd);
    access(0, 30'h44, 0, r_data, r_st, r_wb, r_wba, r_wbl, r_fill, r_fa, r_tmo);
    tests++;
    if (r_data !== 32'hA5A5A5A5 || r_st != 0) begin
      fails++;
      $display("FAIL wmiss_merge got %h want a5a5a5a5", r_data);
    end
    model(0, 30'h45, 0, e_st, e_wb, e_wba, e_wbl, e_rd);
    access(0, 30'h45, 0, r_data, r_st, r_wb, r_wba, r_wbl, r_fill, r_fa, r_tmo);
    tests++;
    if (r_data !== e_rd || r_st != 0) begin
      fails++;
      $display("FAIL wmiss_neighbor got %h want %h", r_data, e_rd);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    proc_read = 1;
    proc_addr = 30'h80;
    repeat (3) @(negedge clk);
    tests++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h20) begin
      fails++;
      $display("FAIL mid_pre got %b/%h want 1/20", mem_read, mem_addr);
    end
    rst_n = 0;
    #1;
    tests++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      fails++;
      $display("FAIL mid_drop got %b/%b want 0/0", mem_read, mem_write);
    end
    proc_read = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      rv[i] = 0;
      rd[i] = 0;
    end
    gold_w.delete();
`ifdef DM_WB_CACHE_PERF_EN
    ref_hits = 0;
    ref_misses = 0;
`endif
    model(0, 30'h80, 0, e_st, e_wb, e_wba, e_wbl, e_rd);
    access(0, 30'h80, 0, r_data, r_st, r_wb, r_wba, r_wbl, r_fill, r_fa, r_tmo);
    tests++;
    if (!r_fill || r_fa !== 28'h20 || r_st != 7 || r_data !== e_rd) begin
      fails++;
      $display("FAIL mid_remiss got %b/%h stall=%0d data=%h want 1/20/7/%h", r_fill, r_fa, r_st, r_data, e_rd);
    end
  endtask

  task automatic test_random();
    bit          w;
    logic [29:0] a;
    logic [31:0] d;
    int          bad;
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      a = {25'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
      d = $urandom;
      model(w, a, d, e_st, e_wb, e_wba, e_wbl, e_rd);
      access(w, a, d, r_data, r_st, r_wb, r_wba, r_wbl, r_fill, r_fa, r_tmo);
      tests++;
      if (r_tmo || r_st != e_st) begin
        fails++;
        $display("FAIL rnd_stall[%0d] a=%h got %0d want %0d", n, a, r_st, e_st);
      end
      tests++;
      if (r_wb != e_wb || (e_wb && (r_wba !== e_wba || r_wbl !== e_wbl))) begin
        fails++;
        $display("FAIL rnd_wb[%0d] got %b/%h/%h want %b/%h/%h", n, r_wb, r_wba, r_wbl, e_wb, e_wba, e_wbl);
      end
      tests++;
      if (r_fill != (e_st != 0) || (r_fill && r_fa !== a[29:2])) begin
        fails++;
        $display("FAIL rnd_fill[%0d] got %b/%h want %b/%h", n, r_fill, r_fa, e_st != 0, a[29:2]);
      end
      if (!w) begin
        tests++;
        if (r_data !== e_rd) begin
          fails++;
          $display("FAIL rnd_rdata[%0d] a=%h got %h want %h", n, a, r_data, e_rd);
        end
      end
      if (r_tmo) bad++;
      if (bad > 3) break;
    end
    tests++;
    if (both_hi) begin
      fails++;
      $display("FAIL rw_exclusive got 1 want 0");
    end
  endtask

`ifdef DM_WB_CACHE_PERF_EN
  task automatic test_perf();
    tests++;
    if (hit_cnt !== 16'(ref_hits) || miss_cnt !== 16'(ref_misses)) begin
      fails++;
      $display("FAIL perf_cnt got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, ref_hits, ref_misses);
    end
    model(0, 30'h80, 0, e_st, e_wb, e_wba, e_wbl, e_rd);
    access(0, 30'h80, 0, r_data, r_st, r_wb, r_wba, r_wbl, r_fill, r_fa, r_tmo);
    @(posedge clk);
    #1;
    proc_read = 1;
    proc_addr = {25'd0, 5'($urandom_range(0, 31))};
    proc_addr[4:2] = 3'd0;
    repeat (70000) @(posedge clk);
    #1;
    proc_read = 0;
    tests++;
    if (hit_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL perf_sat got %h want ffff", hit_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_fill();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_reset_mid();
    test_random();
`ifdef DM_WB_CACHE_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
